nco_iq_mixer_decim: RTL and testbench
=====================================

# nco_iq_mixer_decim

Downstream consumer of the NCO's quadrature outputs. Multiplies each signed ADC sample by the NCO cosine and sine to form I and Q. Integrates DECIM consecutive products per channel (integrate-and-dump) and presents one decimated I/Q pair per frame through a single-entry valid/ready output register. It sits between the NCO/ADC front end and the baseband filter chain.

## Interface
- ADC_W, 12, signed ADC sample width
- NCO_W, 32, NCO sin/cos width (matches NCO fsin_o/fcos_o)
- LO_W, 16, NCO MSBs used in the multiply (truncated, no rounding)
- DECIM, 16, samples per dump; legal range 2..1024
- OUT_W, 24, signed I/Q output width
- clk  in  1  clock; all logic is rising-edge
- reset_n  in  1  synchronous, active-low reset
- adc_data_i  in  ADC_W  signed sample, aligned with nco_valid_i
- nco_valid_i  in  1  NCO out_valid; qualifies adc_data_i, nco_sin_i, nco_cos_i
- nco_sin_i  in  NCO_W  signed NCO sine
- nco_cos_i  in  NCO_W  signed NCO cosine
- out_valid_o  out  1  I/Q result held
- out_ready_i  in  1  consumer accepts the result
- i_o  out  OUT_W  signed decimated I
- q_o  out  OUT_W  signed decimated Q
- overrun_o  out  1  sticky flag: an unread result was overwritten

## Operation
- PROD_W = ADC_W + LO_W. ACC_W = PROD_W + clog2(DECIM). SHIFT = ACC_W - OUT_W; SHIFT must be >= 0 (elaboration error otherwise).
- Stage 1 (on nco_valid_i): p_i = adc * cos[NCO_W-1 -: LO_W], p_q = -(adc * sin[NCO_W-1 -: LO_W]). Both products are full-precision signed. A p_valid flag is registered alongside.
- Stage 2 (on p_valid): sample counter cnt runs 0..DECIM-1.
  - cnt < DECIM-1: acc += p; cnt++.
  - cnt == DECIM-1: result = acc + p is sent to the output stage; acc <= 0; cnt <= 0.
- Output stage: result >> SHIFT (arithmetic, floor) is loaded into i_o/q_o, and out_valid_o <= 1.
- Handshake: the transfer completes on a cycle where out_valid_o && out_ready_i. out_valid_o then drops, unless a new dump loads in the same cycle, in which case it stays 1 with the new data and no overrun is flagged.
- Dump while out_valid_o=1 and out_ready_i=0: the new result overwrites the held one, out_valid_o stays 1, and overrun_o is set.
- Gaps in nco_valid_i stall integration only. The partial frame is kept, and cnt and acc hold their values.
- Reset: acc=0, cnt=0, p_valid=0, i_o=0, q_o=0, out_valid_o=0, overrun_o=0. A partial frame in progress at reset is discarded. overrun_o clears only on reset.

## Timing
- The DECIM-th valid sample is presented at cycle T. Its product registers at T+1, and out_valid_o asserts with data at T+2. Fixed latency of 2 cycles.
- Throughput is one sample per clock, so at most one output every DECIM cycles.
- Output data is stable while out_valid_o=1 and out_ready_i=0, except on an overwrite (overrun).
- The first frame after reset_n rises starts with the first nco_valid_i.

## Configuration
- IQ_MIX_ROUND_EN defined: the output applies round-half-up, i.e. (result + 2^(SHIFT-1)) >> SHIFT, clipped to the max positive OUT_W value if the addition overflows. SHIFT=0 means no rounding.
- IQ_MIX_ROUND_EN undefined: plain floor truncation, with no extra adder.

## Structure
- Shared package nco_mix_pkg holds:
  - the default widths
  - the PROD_W, ACC_W and SHIFT derivation functions
  - the clog2 helper
- Sub-module iq_integrate_dump: one channel (accumulator, dump, shift/round), instantiated twice for I and Q. The counter and handshake logic are shared and live in the top level.

## Test plan
- Constant accumulate: adc=1000, cos=0x7FFF_FFFF, sin=0, DECIM=16, continuous valid. Expected: i_o=2047937 (truncate) or 2047938 (IQ_MIX_ROUND_EN), q_o=0, out_valid_o exactly 2 cycles after the 16th sample.
- Extreme negative: adc=-2048, cos=0x8000_0000, sin=0x8000_0000. Expected: i_o=4194304, q_o=-4194304, no wrap.
- Gapped valid: 16 samples spread with random 0-5 cycle gaps produce the same result as the continuous case. Exactly one output.
- Backpressure: out_ready_i=0 across two dumps. Expected: the second result replaces the first, overrun_o=1. Ready and dump in the same cycle leaves out_valid_o=1 with overrun_o unchanged.
- Reset mid-frame: reset_n low for 1 cycle after 7 samples. All outputs return to 0. The next output appears only after 16 new samples and equals the clean-frame value.

Source files
------------

// File: rtl/nco_mix_pkg.sv
// nco_mix_pkg: shared widths and width-derivation helpers for the NCO I/Q
// mixer / decimator slice.
package nco_mix_pkg;

    // Default widths of the mixer front end.
    localparam int ADC_W_DEF = 12;
    localparam int NCO_W_DEF = 32;
    localparam int LO_W_DEF  = 16;
    localparam int DECIM_DEF = 16;
    localparam int OUT_W_DEF = 24;

    // Ceiling log2, usable at elaboration time.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Full-precision signed product of an ADC sample and a truncated LO value.
    function automatic int prod_width(input int adc_w, input int lo_w);
        return adc_w + lo_w;
    endfunction

    // Accumulator must hold DECIM worst-case products without wrapping.
    function automatic int acc_width(input int adc_w, input int lo_w, input int decim);
        return prod_width(adc_w, lo_w) + clog2(decim);
    endfunction

    // Right shift that maps the accumulator onto the output width.
    function automatic int shift_amount(input int adc_w, input int lo_w, input int decim,
                                        input int out_w);
        return acc_width(adc_w, lo_w, decim) - out_w;
    endfunction

endpackage

// File: rtl/iq_integrate_dump.sv
// iq_integrate_dump: one mixer channel. Integrates signed products, and on the
// last product of a frame dumps acc + p, scaled down to OUT_W, into its output
// register while clearing the accumulator.
// Build macro IQ_MIX_ROUND_EN: round-half-up (with positive clip) instead of
// floor truncation when scaling the dump.
module iq_integrate_dump
    import nco_mix_pkg::*;
#(
    parameter int PROD_W = prod_width(ADC_W_DEF, LO_W_DEF),
    parameter int ACC_W  = acc_width(ADC_W_DEF, LO_W_DEF, DECIM_DEF),
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_p_valid,
    input  logic              i_last,
    input  logic [PROD_W-1:0] i_p,
    output logic [OUT_W-1:0]  o_data
);

    localparam int SHIFT = ACC_W - OUT_W;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_p_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic [OUT_W-1:0]        w_scaled;
    logic [OUT_W-1:0]        r_data;

    assign w_p_ext = ACC_W'($signed(i_p));
    assign w_sum   = r_acc + w_p_ext;

`ifdef IQ_MIX_ROUND_EN
    if (SHIFT == 0) begin : g_no_round
        assign w_scaled = OUT_W'(w_sum);
    end else begin : g_round
        localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
        logic [ACC_W:0] w_rnd;
        logic           w_unused_lsbs;
        assign w_rnd         = {w_sum[ACC_W-1], w_sum} + HALF;
        assign w_unused_lsbs = ^w_rnd[SHIFT-1:0];
        // Adding half an LSB can only overflow upwards; clip to the largest positive code.
        assign w_scaled = (w_rnd[ACC_W] != w_rnd[ACC_W-1]) ? {1'b0, {(OUT_W - 1){1'b1}}}
                                                           : w_rnd[ACC_W-1:SHIFT];
    end
`else
    if (SHIFT == 0) begin : g_no_shift
        assign w_scaled = OUT_W'(w_sum);
    end else begin : g_floor
        logic w_unused_lsbs;
        assign w_unused_lsbs = ^w_sum[SHIFT-1:0];
        // Dropping the low bits of a two's-complement value is an arithmetic floor shift.
        assign w_scaled = w_sum[ACC_W-1:SHIFT];
    end
`endif

    // Integrate products; the last product of a frame restarts the accumulator at zero.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_p_valid) begin
            r_acc <= i_last ? '0 : w_sum;
        end
    end

    // Capture the scaled frame sum when the frame completes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data <= '0;
        end else if (i_p_valid && i_last) begin
            r_data <= w_scaled;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/nco_iq_mixer_decim.sv
// nco_iq_mixer_decim: mixes signed ADC samples with the NCO cosine/sine into
// I/Q, integrates DECIM products per channel and presents each decimated pair
// through a single-entry valid/ready register with a sticky overrun flag.
// Build macro IQ_MIX_ROUND_EN: round-half-up output scaling (see iq_integrate_dump).
module nco_iq_mixer_decim
    import nco_mix_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEF,
    parameter int NCO_W = NCO_W_DEF,
    parameter int LO_W  = LO_W_DEF,
    parameter int DECIM = DECIM_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] adc_data_i,
    input  logic             nco_valid_i,
    input  logic [NCO_W-1:0] nco_sin_i,
    input  logic [NCO_W-1:0] nco_cos_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] i_o,
    output logic [OUT_W-1:0] q_o,
    output logic             overrun_o
);

    localparam int PROD_W = prod_width(ADC_W, LO_W);
    localparam int ACC_W  = acc_width(ADC_W, LO_W, DECIM);
    localparam int SHIFT  = shift_amount(ADC_W, LO_W, DECIM, OUT_W);
    localparam int CNT_W  = clog2(DECIM);

    if (SHIFT < 0) begin : g_bad_shift
        $error("nco_iq_mixer_decim: OUT_W exceeds the accumulator width");
    end
    if (DECIM < 2 || DECIM > 1024) begin : g_bad_decim
        $error("nco_iq_mixer_decim: DECIM must lie in 2..1024");
    end

    // Stage 1: multiply by the truncated LO MSBs at full precision.
    logic signed [PROD_W-1:0] w_adc_x;
    logic signed [PROD_W-1:0] w_cos_x;
    logic signed [PROD_W-1:0] w_sin_x;
    logic signed [PROD_W-1:0] w_prod_i;
    logic signed [PROD_W-1:0] w_prod_q;
    logic [PROD_W-1:0]        r_prod_i;
    logic [PROD_W-1:0]        r_prod_q;
    logic                     r_p_valid;

    assign w_adc_x  = PROD_W'($signed(adc_data_i));
    assign w_cos_x  = PROD_W'($signed(nco_cos_i[NCO_W-1 -: LO_W]));
    assign w_sin_x  = PROD_W'($signed(nco_sin_i[NCO_W-1 -: LO_W]));
    assign w_prod_i = w_adc_x * w_cos_x;
    assign w_prod_q = -(w_adc_x * w_sin_x);

    if (NCO_W > LO_W) begin : g_lo_trunc
        logic w_unused_nco_lsbs;
        assign w_unused_nco_lsbs = ^{nco_sin_i[NCO_W-LO_W-1:0], nco_cos_i[NCO_W-LO_W-1:0]};
    end

    // Product-valid flag follows the NCO qualifier one cycle later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_p_valid <= 1'b0;
        end else begin
            r_p_valid <= nco_valid_i;
        end
    end

    // Register the products of each qualified sample.
    // NOTE: product data has no reset; r_p_valid alone decides whether it is consumed.
    always_ff @(posedge clk) begin
        if (nco_valid_i) begin
            r_prod_i <= w_prod_i;
            r_prod_q <= w_prod_q;
        end
    end

    // Stage 2: shared sample counter marks the last product of each frame.
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic             w_dump;

    assign w_last = (r_cnt == CNT_W'(DECIM - 1));
    assign w_dump = r_p_valid && w_last;

    // Count products in the frame; gaps in r_p_valid leave the count untouched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_p_valid) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    iq_integrate_dump #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_chan_i (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_p_valid (r_p_valid),
        .i_last    (w_last),
        .i_p       (r_prod_i),
        .o_data    (i_o)
    );

    iq_integrate_dump #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_chan_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_p_valid (r_p_valid),
        .i_last    (w_last),
        .i_p       (r_prod_q),
        .o_data    (q_o)
    );

    // Output handshake: a dump always (re)loads; an unread dump being replaced raises overrun.
    logic r_out_valid;
    logic r_overrun;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_dump) begin
            r_out_valid <= 1'b1;
            if (r_out_valid && !out_ready_i) begin
                r_overrun <= 1'b1;
            end
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_nco_iq_mixer_decim.sv
// tb_nco_iq_mixer_decim: directed stimulus with a frame-level arithmetic model
// compared every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_nco_iq_mixer_decim;

    localparam int     DECIM   = 16;
    localparam int     SHIFT   = 8;          // 12 + 16 + log2(16) - 24
    localparam longint OUT_MAX = 8388607;    // 2^23 - 1

`ifdef IQ_MIX_ROUND_EN
    localparam longint EXP_1000  = 2047938;
    localparam longint EXP_500   = 1023969;
    localparam longint EXP_N1000 = -2047937;
`else
    localparam longint EXP_1000  = 2047937;
    localparam longint EXP_500   = 1023968;
    localparam longint EXP_N1000 = -2047938;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] adc_data_i = '0;
    logic        nco_valid_i = 1'b0;
    logic [31:0] nco_sin_i = '0;
    logic [31:0] nco_cos_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [23:0] i_o;
    logic [23:0] q_o;
    logic        overrun_o;

    always #5 clk = ~clk;

    nco_iq_mixer_decim dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .adc_data_i  (adc_data_i),
        .nco_valid_i (nco_valid_i),
        .nco_sin_i   (nco_sin_i),
        .nco_cos_i   (nco_cos_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .i_o         (i_o),
        .q_o         (q_o),
        .overrun_o   (overrun_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int     cyc = 0;
    bit     chk_en = 1'b0;
    longint m_sum_i, m_sum_q;
    int     m_n;
    bit     m_pend;
    longint m_pend_i, m_pend_q;
    bit     e_valid, e_ovr;
    longint e_i, e_q;

    function automatic longint scale(input longint s);
        longint r;
`ifdef IQ_MIX_ROUND_EN
        r = (s + longint'(2 ** (SHIFT - 1))) >>> SHIFT;
        if (r > OUT_MAX) r = OUT_MAX;
`else
        r = s >>> SHIFT;
`endif
        return r;
    endfunction

    initial begin
        m_sum_i = 0; m_sum_q = 0; m_n = 0; m_pend = 0; m_pend_i = 0; m_pend_q = 0;
        e_valid = 0; e_ovr = 0; e_i = 0; e_q = 0;
    end

    // Model: a frame of DECIM accepted samples becomes visible two cycles after its last sample.
    always @(posedge clk) begin
        int a, c, s;
        cyc++;
        if (!reset_n) begin
            m_sum_i = 0; m_sum_q = 0; m_n = 0; m_pend = 0;
            e_valid = 0; e_ovr = 0; e_i = 0; e_q = 0;
        end else begin
            if (m_pend) begin
                if (e_valid && !out_ready_i) e_ovr = 1;
                e_valid = 1; e_i = m_pend_i; e_q = m_pend_q; m_pend = 0;
            end else if (e_valid && out_ready_i) begin
                e_valid = 0;
            end
            if (nco_valid_i) begin
                a = $signed(adc_data_i);
                c = $signed(nco_cos_i[31:16]);
                s = $signed(nco_sin_i[31:16]);
                m_sum_i += longint'(a) * longint'(c);
                m_sum_q -= longint'(a) * longint'(s);
                m_n++;
                if (m_n == DECIM) begin
                    m_pend = 1; m_pend_i = scale(m_sum_i); m_pend_q = scale(m_sum_q);
                    m_sum_i = 0; m_sum_q = 0; m_n = 0;
                end
            end
        end
    end

    // Compare process plus handshake bookkeeping, away from the active edge.
    bit prev_valid = 1'b0;
    int rise_cyc = 0;
    int out_count = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out_valid", longint'(out_valid_o), longint'(e_valid));
            check("cyc_i", longint'($signed(i_o)), e_i);
            check("cyc_q", longint'($signed(q_o)), e_q);
            check("cyc_overrun", longint'(overrun_o), longint'(e_ovr));
        end
        if (out_valid_o && !prev_valid) rise_cyc = cyc;
        if (out_valid_o && out_ready_i) out_count++;
        prev_valid = out_valid_o;
    end

    // ---------------- stimulus helpers ----------------
    int last_cyc = 0;

    task automatic send(input int adc, input logic [31:0] cosv, input logic [31:0] sinv);
        adc_data_i  = 12'(adc);
        nco_cos_i   = cosv;
        nco_sin_i   = sinv;
        nco_valid_i = 1'b1;
        last_cyc    = cyc;
        @(posedge clk); #1;
        nco_valid_i = 1'b0;
    endtask

    task automatic send_frame(input int adc, input logic [31:0] cosv, input logic [31:0] sinv,
                              input int n);
        for (int k = 0; k < n; k++) send(adc, cosv, sinv);
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) for out_valid_o; leaves time just after a falling edge.
    task automatic wait_valid(input string name, input int max_cyc);
        int k = 0;
        while (!out_valid_o && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        #1;
        check(name, longint'(out_valid_o), 1);
    endtask

    task automatic realign();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("rst_valid", longint'(out_valid_o), 0);
        check("rst_i", longint'($signed(i_o)), 0);
        check("rst_q", longint'($signed(q_o)), 0);
        check("rst_overrun", longint'(overrun_o), 0);
        realign();
        reset_n = 1'b1;
        idle(2);

        // Constant accumulate, continuous valid
        send_frame(1000, 32'h7FFF_FFFF, 32'h0, DECIM);
        wait_valid("t1_valid", 10);
        check("t1_i", longint'($signed(i_o)), EXP_1000);
        check("t1_q", longint'($signed(q_o)), 0);
        check("t1_latency", longint'(rise_cyc - last_cyc), 2);
        realign();

        // Extreme negative sample against most-negative LO
        send_frame(-2048, 32'h8000_0000, 32'h8000_0000, DECIM);
        wait_valid("t2_valid", 10);
        check("t2_i", longint'($signed(i_o)), 4194304);
        check("t2_q", longint'($signed(q_o)), -4194304);
        realign();

        // Gapped valid: same frame spread over random idle cycles
        out_count = 0;
        for (int k = 0; k < DECIM; k++) begin
            send(1000, 32'h7FFF_FFFF, 32'h0);
            idle(int'($urandom_range(0, 5)));
        end
        wait_valid("t3_valid", 10);
        check("t3_i", longint'($signed(i_o)), EXP_1000);
        idle(20);
        check("t3_count", longint'(out_count), 1);

        // Ready and dump in the same cycle: data replaced, no overrun
        out_ready_i = 1'b0;
        send_frame(1000, 32'h7FFF_FFFF, 32'h0, DECIM);
        wait_valid("t4_first_valid", 10);
        check("t4_first_i", longint'($signed(i_o)), EXP_1000);
        realign();
        send_frame(500, 32'h7FFF_FFFF, 32'h0, DECIM);
        out_ready_i = 1'b1;
        realign();
        out_ready_i = 1'b0;
        @(negedge clk); #1;
        check("t4_valid_kept", longint'(out_valid_o), 1);
        check("t4_no_overrun", longint'(overrun_o), 0);
        check("t4_new_i", longint'($signed(i_o)), EXP_500);
        realign();

        // Dump while held and not ready: overwrite plus overrun
        send_frame(-1000, 32'h7FFF_FFFF, 32'h0, DECIM);
        idle(1);
        check("t5_overrun", longint'(overrun_o), 1);
        check("t5_valid", longint'(out_valid_o), 1);
        check("t5_i", longint'($signed(i_o)), EXP_N1000);
        out_ready_i = 1'b1;
        idle(1);
        check("t5_drained", longint'(out_valid_o), 0);
        check("t5_overrun_sticky", longint'(overrun_o), 1);

        // Reset mid-frame
        send_frame(1000, 32'h7FFF_FFFF, 32'h0, 7);
        reset_n = 1'b0;
        realign();
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("t6_rst_valid", longint'(out_valid_o), 0);
        check("t6_rst_i", longint'($signed(i_o)), 0);
        check("t6_rst_q", longint'($signed(q_o)), 0);
        check("t6_rst_overrun", longint'(overrun_o), 0);
        realign();
        send_frame(1000, 32'h7FFF_FFFF, 32'h0, DECIM - 1);
        idle(3);
        check("t6_no_early_out", longint'(out_valid_o), 0);
        send(1000, 32'h7FFF_FFFF, 32'h0);
        wait_valid("t6_valid", 10);
        check("t6_i", longint'($signed(i_o)), EXP_1000);
        realign();
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
